// File: rtl/mem_pkg.sv
// mem_pkg: shared widths, depths and FSM state encoding for the burst master.
package mem_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int LEN_W = 4;
  localparam int MEM_DEPTH = 256;
  typedef enum logic [2:0] {IDLE, WRITE, WDONE, READ, RDRAIN} state_t;
endpackage

// File: rtl/rd_return_fifo.sv
// rd_return_fifo: 3-deep read-return buffer; head is presented combinationally.
module rd_return_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [1:0]   count
);
  logic [W-1:0] mem [3];
  logic [1:0] rptr, wptr;
  always_ff @(posedge clk)
    if (push) mem[wptr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr == 2'd2 ? 2'd0 : wptr + 2'd1;
      if (pop) rptr <= rptr == 2'd2 ? 2'd0 : rptr + 2'd1;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  assign valid = count != 2'd0;
  // Gated so the data output reads zero while empty, including after reset.
  assign dout = valid ? mem[rptr] : '0;
endmodule

// File: rtl/mem_burst_master.sv
// mem_burst_master: turns load/store bursts into per-cycle accesses to a
// one-cycle-latency word memory, with valid/ready on both data streams.
module mem_burst_master #(
  parameter int DATA_W    = mem_pkg::DATA_W,
  parameter int ADDR_W    = mem_pkg::ADDR_W,
  parameter int LEN_W     = mem_pkg::LEN_W,
  parameter int MEM_DEPTH = mem_pkg::MEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              busy,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);
  import mem_pkg::*;
  state_t state;
  logic [ADDR_W-1:0] cur_addr, next_addr;
  logic [LEN_W:0] remaining;
  logic [1:0] tag, fifo_count;
  logic [2:0] credit;
  logic pop, issue, drained;
  assign pop       = rd_valid & rd_ready;
  // Words already owed to the buffer after this cycle's hand-off; must stay below 3.
  assign credit    = {2'b0, tag[0]} + {2'b0, tag[1]} + {1'b0, fifo_count} - {2'b0, pop};
  assign issue     = state == READ && credit < 3'd3;
  assign drained   = tag == 2'b00 && fifo_count == 2'd0;
  assign next_addr = cur_addr == ADDR_W'(MEM_DEPTH - 1) ? '0 : cur_addr + ADDR_W'(1);
  assign req_ready = state == IDLE;
  assign wr_ready  = state == WRITE;
  assign busy      = state != IDLE;
  assign done      = state == WDONE || (state == RDRAIN && drained);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state            <= IDLE;
      cur_addr         <= '0;
      remaining        <= '0;
      tag              <= '0;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      mem_write_data   <= '0;
    end else begin
      tag <= {tag[0], issue};
      case (state)
        IDLE:
          if (req_valid) begin
            cur_addr  <= req_addr;
            remaining <= {1'b0, req_len} + (LEN_W + 1)'(1);
            state     <= req_write ? WRITE : READ;
          end
        WRITE: begin
          mem_write_enable <= wr_valid;
          if (wr_valid) begin
            mem_address    <= cur_addr;
            mem_write_data <= wr_data;
            cur_addr       <= next_addr;
            remaining      <= remaining - (LEN_W + 1)'(1);
            if (remaining == (LEN_W + 1)'(1)) state <= WDONE;
          end
        end
        WDONE: begin
          mem_write_enable <= 1'b0;
          state            <= IDLE;
        end
        READ: begin
          mem_write_enable <= 1'b0;
          if (issue) begin
            mem_address <= cur_addr;
            cur_addr    <= next_addr;
            remaining   <= remaining - (LEN_W + 1)'(1);
            if (remaining == (LEN_W + 1)'(1)) state <= RDRAIN;
          end
        end
        RDRAIN:
          if (drained) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  // The in-flight tag leaves the shift exactly when the memory's read data is valid.
  rd_return_fifo #(.W(DATA_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tag[1]),
    .din   (mem_read_data),
    .pop   (pop),
    .dout  (rd_data),
    .valid (rd_valid),
    .count (fifo_count)
  );
endmodule

// File: tb/tb_mem_burst_master.sv
// tb_mem_burst_master: directed bench with a registered-read memory model.
module tb_mem_burst_master;
  logic clk, rst_n;
  logic req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [3:0] req_len;
  logic wr_valid, wr_ready, rd_valid, rd_ready, done, busy, mem_write_enable;
  logic [31:0] wr_data, rd_data, mem_address, mem_write_data, mem_read_data;
  logic [31:0] mem [256];
  int vectors = 0;
  int miscompares = 0;

  mem_burst_master dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .busy(busy), .mem_write_enable(mem_write_enable),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_address[7:0]] <= mem_write_data;
    mem_read_data <= mem[mem_address[7:0]];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input int len, input logic [31:0] d0, input bit gaps);
    int n, sent, cyc;
    bit v;
    n = len + 1;
    sent = 0;
    cyc = 0;
    req_valid = 1; req_write = 1; req_addr = a; req_len = 4'(len); wr_valid = 0;
    tick;
    req_valid = 0;
    chk("wr_busy", 32'(busy), 1);
    chk("wr_ready", 32'(wr_ready), 1);
    while (sent < n && cyc < 64) begin
      v = gaps ? (cyc % 2 == 0) : 1'b1;
      wr_valid = v;
      wr_data = d0 + 32'(sent);
      tick;
      chk("wr_we", 32'(mem_write_enable), 32'(v));
      if (v) begin
        chk("wr_addr", mem_address, (a + 32'(sent)) & 32'hFF);
        chk("wr_data", mem_write_data, d0 + 32'(sent));
        sent++;
      end
      chk("wr_done", 32'(done), 32'(sent == n));
      cyc++;
    end
    chk("wr_count", 32'(sent), 32'(n));
    wr_valid = 0;
    tick;
    chk("wr_done_off", 32'(done), 0);
    chk("wr_we_off", 32'(mem_write_enable), 0);
    chk("wr_idle", 32'(req_ready), 1);
    chk("wr_not_busy", 32'(busy), 0);
  endtask

  initial begin
    int k, cyc;
    bit got_done;
    for (int i = 0; i < 256; i++) mem[i] = 32'hC000_0000 | 32'(i);
    rst_n = 0; req_valid = 0; req_write = 0; req_addr = 0; req_len = 0;
    wr_valid = 0; wr_data = 0; rd_ready = 0;
    tick; tick;
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_we", 32'(mem_write_enable), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_wr_ready", 32'(wr_ready), 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_addr", mem_address, 0);
    rst_n = 1;
    tick;

    // Plain write burst 0x10..0x13
    do_write(32'h10, 3, 32'hA0, 0);
    chk("mem_10", mem[8'h10], 32'hA0);
    chk("mem_13", mem[8'h13], 32'hA3);

    // Read back with rd_ready held high
    req_valid = 1; req_write = 0; req_addr = 32'h10; req_len = 3; rd_ready = 1;
    tick;
    req_valid = 0;
    chk("rd_busy", 32'(busy), 1);
    chk("rd_v0", 32'(rd_valid), 0);
    tick;
    chk("rd_addr0", mem_address, 32'h10);
    chk("rd_we", 32'(mem_write_enable), 0);
    chk("rd_v1", 32'(rd_valid), 0);
    tick;
    chk("rd_v2", 32'(rd_valid), 0);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("rd_seq_valid", 32'(rd_valid), 1);
      chk("rd_seq_data", rd_data, 32'hA0 + 32'(i));
      chk("rd_seq_done", 32'(done), 0);
    end
    tick;
    chk("rd_done", 32'(done), 1);
    chk("rd_empty", 32'(rd_valid), 0);
    tick;
    chk("rd_done_off", 32'(done), 0);
    chk("rd_idle", 32'(busy), 0);

    // 16-word read with consumer accepting one cycle in three
    req_valid = 1; req_write = 0; req_addr = 32'h20; req_len = 4'hF; rd_ready = 0;
    tick;
    req_valid = 0;
    k = 0; cyc = 0; got_done = 0;
    while (!got_done && cyc < 200) begin
      rd_ready = (cyc % 3 == 0);
      if (rd_valid) chk("rd_stall_data", rd_data, 32'hC000_0020 + 32'(k));
      if (rd_valid && rd_ready) k++;
      if (done) got_done = 1;
      tick;
      cyc++;
    end
    chk("rd16_done_seen", 32'(got_done), 1);
    chk("rd16_words", 32'(k), 16);
    chk("rd16_idle", 32'(busy), 0);
    rd_ready = 0;

    // Address wrap and gapped write data
    do_write(32'hFE, 3, 32'hB0, 0);
    chk("mem_ff", mem[8'hFF], 32'hB1);
    chk("mem_00", mem[8'h00], 32'hB2);
    chk("mem_01", mem[8'h01], 32'hB3);
    do_write(32'h30, 3, 32'hD0, 1);
    chk("mem_33", mem[8'h33], 32'hD3);

    // Reset in the middle of a write: enable must drop without a clock
    req_valid = 1; req_write = 1; req_addr = 32'h40; req_len = 3; wr_valid = 1; wr_data = 32'hE0;
    tick;
    req_valid = 0;
    tick;
    chk("rstw_we_pre", 32'(mem_write_enable), 1);
    #2 rst_n = 0;
    #1;
    chk("rstw_we", 32'(mem_write_enable), 0);
    chk("rstw_busy", 32'(busy), 0);
    chk("rstw_wr_ready", 32'(wr_ready), 0);
    chk("rstw_addr", mem_address, 0);
    wr_valid = 0;
    rst_n = 1;
    tick;

    // Reset in the middle of a read
    req_valid = 1; req_write = 0; req_addr = 32'h20; req_len = 4'hF; rd_ready = 0;
    tick;
    req_valid = 0;
    tick; tick; tick;
    chk("rstr_valid_pre", 32'(rd_valid), 1);
    chk("rstr_data_pre", rd_data, 32'hC000_0020);
    #2 rst_n = 0;
    #1;
    chk("rstr_valid", 32'(rd_valid), 0);
    chk("rstr_data", rd_data, 0);
    chk("rstr_busy", 32'(busy), 0);
    chk("rstr_req_ready", 32'(req_ready), 1);
    chk("rstr_done", 32'(done), 0);
    chk("rstr_addr", mem_address, 0);
    tick;
    rst_n = 1;
    tick;
    chk("post_rst_ready", 32'(req_ready), 1);
    chk("post_rst_valid", 32'(rd_valid), 0);

    // Single-word read after reset
    req_valid = 1; req_write = 0; req_addr = 32'h12; req_len = 0; rd_ready = 1;
    tick;
    req_valid = 0;
    tick; tick;
    chk("one_v_early", 32'(rd_valid), 0);
    tick;
    chk("one_valid", 32'(rd_valid), 1);
    chk("one_data", rd_data, 32'hA2);
    tick;
    chk("one_done", 32'(done), 1);
    tick;
    chk("one_idle", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_burst_master.md
Name: mem_burst_master

Overview:
- Initiator side of the word-addressed data memory: converts datapath load/store burst requests into per-cycle memory accesses.
- Drives the memory's write-enable, address and write-data pins and collects its read data.
- The memory returns `mem_read_data` one clock after it samples an address. This block hides that latency and adds valid/ready flow control on both data streams.
- Sits between the execute/store stage and the memory.

Parameters:
- DATA_W, 32, memory word width.
- ADDR_W, 32, memory address width (word address).
- LEN_W, 4, burst length field width; a burst is `req_len+1` words (1..16).
- MEM_DEPTH, 256, number of memory words; the address increment wraps modulo MEM_DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  burst request valid.
- req_ready  out  1  request accepted when `req_valid & req_ready`.
- req_write  in  1  1 = write burst, 0 = read burst.
- req_addr  in  ADDR_W  start word address.
- req_len  in  LEN_W  words minus one.
- wr_valid  in  1  write-data word valid.
- wr_ready  out  1  write-data word accepted.
- wr_data  in  DATA_W  write-data word.
- rd_valid  out  1  read-data word valid.
- rd_ready  in  1  consumer accepts read word.
- rd_data  out  DATA_W  read-data word.
- done  out  1  one-cycle pulse at burst completion.
- busy  out  1  high from request accept until done.
- mem_write_enable  out  1  to memory write_enable.
- mem_address  out  ADDR_W  to memory address.
- mem_write_data  out  DATA_W  to memory write_data.
- mem_read_data  in  DATA_W  from memory, registered inside the memory.

Behaviour:
- Interface rule: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values:
  - state IDLE;
  - outputs: `req_ready`=1 (combinational from IDLE, so it reads 1 once reset is applied); every other output 0;
  - read buffer empty; in-flight tags cleared.
- Reset asserted mid-burst: immediate abort. `mem_write_enable` drops without waiting for a clock; there is no done pulse and buffered read data is discarded.
- FSM states:
  - IDLE: `req_ready`=1.
    - On accept, latch addr, remaining count = `req_len+1` and op.
    - Go to WRITE or READ; `busy`=1 from the next cycle.
  - WRITE:
    - `wr_ready`=1.
    - On each `wr_valid & wr_ready`, register `mem_write_enable`=1, `mem_address`=cur_addr, `mem_write_data`=`wr_data` (visible the following cycle, so the memory writes on the next edge).
    - Then cur_addr = (cur_addr+1) mod MEM_DEPTH; count-1.
    - On the cycle `wr_valid`=0, `mem_write_enable` is registered 0 (no write).
    - After the last word is registered, go to WDONE.
  - WDONE: `mem_write_enable`=0, `done`=1 for one cycle, then IDLE.
  - READ:
    - Issue one address per cycle while credit allows: register `mem_address`=cur_addr, `mem_write_enable`=0, and push an in-flight tag into a 2-stage shift.
    - The memory samples the address one edge later; the block captures `mem_read_data` into the read buffer on the following edge.
    - Total latency from issue (address registered) to buffer entry is 2 cycles.
    - After the last issue, go to RDRAIN.
  - RDRAIN: wait until in-flight = 0 and buffer empty, with the last word handed off via `rd_valid & rd_ready`; pulse `done`, then IDLE.
- Read buffer and credit:
  - 3-entry FIFO feeding `rd_data`/`rd_valid` from its head.
  - Issue only if (inflight + fifo_count − pop) < 3, where pop = `rd_valid & rd_ready` this cycle. This guarantees no overflow.
  - Sustains 1 word/cycle when `rd_ready` is held high.
  - `rd_data` is stable while `rd_valid & !rd_ready`.
- Ordering:
  - Read words are returned in address order.
  - Write and read bursts never overlap. The next request is accepted only in IDLE, so a write is always committed before a following read issues.
- Wrap: address MEM_DEPTH−1 increments to 0.
- Length: `req_len`=0 gives a single-word burst. `req_len`=all-ones gives 16 words.
- Simultaneous events:
  - In IDLE, a pending `done` and a new `req_valid` cannot coincide: `done` is emitted from WDONE/RDRAIN, and `req_ready` is 0 in those states.
  - `wr_valid` outside WRITE is ignored (`wr_ready`=0).

Decomposition:
- Shared package (`mem_pkg`): DATA_W, ADDR_W, MEM_DEPTH constants; FSM state enum {IDLE, WRITE, WDONE, READ, RDRAIN}.
- Sub-module: `rd_return_fifo`, a 3-deep synchronous FIFO with count output and async active-low reset.
- Top level holds the FSM, address/count registers and the in-flight shift.

Test Plan:
- Write burst addr 0x10, len 3, data 0xA0..0xA3, `wr_valid` always 1 → 4 consecutive `mem_write_enable` cycles with addresses 0x10..0x13; done 1 cycle after the last; memory holds the words.
- Read back addr 0x10, len 3, `rd_ready`=1 → `rd_data` A0,A1,A2,A3 on 4 consecutive cycles; first `rd_valid` appears 3 cycles after accept; then done.
- Read len 15 with `rd_ready` toggling 1,0,0,1… → no word lost or duplicated; inflight+count never exceeds 3; `rd_data` is held during stalls.
- Write at addr 0xFE, len 3 → addresses 0xFE, 0xFF, 0x00, 0x01 (wrap).
- Write with `wr_valid` gaps (1,0,1,0…) → `mem_write_enable` low on gap cycles; still exactly 4 writes.
- Assert `rst_n`=0 mid read burst → all outputs drop to reset values asynchronously; after release `req_ready`=1 and a new single-word read returns correct data.
